// File: rtl/rmw_pkg.sv
// Shared types and constants for the read-modify-write sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rmw_pkg;

   // Memory RMW operations, encoded as they arrive from the CPU decoder.
   typedef enum logic [2:0] {
      OP_ASL = 3'd0,
      OP_LSR = 3'd1,
      OP_ROL = 3'd2,
      OP_ROR = 3'd3,
      OP_INC = 3'd4,
      OP_DEC = 3'd5
   } rmw_op_t;

   // Bus sequence: one read, a dummy write of the old value, then the real write.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DUMMY = 2'd2,
      ST_WRITE = 2'd3
   } rmw_state_t;

   // Shared ALU opcodes used by this block.
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_ASL = 4'b1000;
   localparam logic [3:0] ALU_ROL = 4'b1001;
   localparam logic [3:0] ALU_LSR = 4'b1010;
   localparam logic [3:0] ALU_ROR = 4'b1011;

   // Bit positions inside the {N,V,Z,C} flag nibble.
   localparam int FLG_N = 3;
   localparam int FLG_V = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_C = 0;

   // Codes 6 and 7 are reserved and must not start a sequence.
   function automatic logic op_valid(input logic [2:0] o);
      return (o <= 3'd5);
   endfunction

   // INC/DEC use the adder with a constant 1 operand; shifts take no B operand.
   function automatic logic is_incdec(input rmw_op_t o);
      return (o == OP_INC) || (o == OP_DEC);
   endfunction

   function automatic logic [3:0] alu_ctl_of(input rmw_op_t o);
      logic [3:0] ctl;
      case (o)
         OP_ASL:  ctl = ALU_ASL;
         OP_LSR:  ctl = ALU_LSR;
         OP_ROL:  ctl = ALU_ROL;
         OP_ROR:  ctl = ALU_ROR;
         OP_INC:  ctl = ALU_ADD;
         OP_DEC:  ctl = ALU_SUB;
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

   // Shifts/rotates own N, Z and C; INC/DEC leave C and V alone.
   function automatic logic [3:0] flg_mask_of(input rmw_op_t o);
      logic [3:0] m;
      m        = '0;
      m[FLG_N] = 1'b1;
      m[FLG_Z] = 1'b1;
      m[FLG_C] = !is_incdec(o);
      return m;
   endfunction

endpackage

// File: rtl/rmw_sequencer.sv
// Sequences 6502 memory RMW ops: read, dummy write of old value, final write of ALU result.
// Latency: start edge to final write is 3 cycles; back in IDLE on the 4th (4-cycle throughput).
// Backpressure: rdy low stalls only the READ cycle; both writes are unconditional.
module rmw_sequencer
   import rmw_pkg::*;
#(
   parameter int ADDR_W = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic              c_in,
   input  logic              rdy,
   input  logic [7:0]        rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_re,
   output logic              bus_we,
   output logic [7:0]        wdata,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic              alu_c,
   output logic [3:0]        alu_control,
   input  logic [7:0]        alu_y,
   input  logic [3:0]        alu_flgs,
   output logic              flg_we,
   output logic [3:0]        flg_mask,
   output logic [3:0]        flg_val,
   output logic              busy,
   output logic              done
);

   rmw_state_t        state_q;
   rmw_state_t        state_d;
   rmw_op_t           op_q;
   logic [ADDR_W-1:0] addr_q;
   logic              c_q;
   logic [7:0]        operand_q;
   logic [7:0]        result_q;
   logic [3:0]        flags_q;
   logic              accept;

   // A new request is taken only from IDLE and only with a defined opcode.
   assign accept = (state_q == ST_IDLE) && start && op_valid(op);

   // State register; async reset drops all strobes immediately since outputs decode state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, address, carry and ALU result capture along the sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_ASL;
         addr_q    <= '0;
         c_q       <= 1'b0;
         operand_q <= '0;
         result_q  <= '0;
         flags_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= rmw_op_t'(op);
                  addr_q <= addr;
                  c_q    <= c_in;
               end
            end
            ST_READ: begin
               if (rdy) begin
                  operand_q <= rdata;
               end
            end
            ST_DUMMY: begin
               result_q <= alu_y;
               flags_q  <= alu_flgs;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and output decode; every output is zero unless its state drives it.
   always_comb begin
      state_d     = state_q;
      bus_addr    = '0;
      bus_re      = 1'b0;
      bus_we      = 1'b0;
      wdata       = '0;
      alu_a       = '0;
      alu_b       = '0;
      alu_c       = 1'b0;
      alu_control = ALU_ADD;
      flg_we      = 1'b0;
      flg_mask    = '0;
      flg_val     = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            busy     = 1'b1;
            bus_addr = addr_q;
            bus_re   = 1'b1;
            if (rdy) begin
               state_d = ST_DUMMY;
            end
         end
         ST_DUMMY: begin
            // The 2A03 rewrites the unmodified value while the ALU works on it.
            busy        = 1'b1;
            bus_addr    = addr_q;
            bus_we      = 1'b1;
            wdata       = operand_q;
            alu_a       = operand_q;
            alu_b       = is_incdec(op_q) ? 8'd1 : 8'd0;
            alu_c       = c_q;
            alu_control = alu_ctl_of(op_q);
            state_d     = ST_WRITE;
         end
         ST_WRITE: begin
            busy     = 1'b1;
            bus_addr = addr_q;
            bus_we   = 1'b1;
            wdata    = result_q;
            flg_we   = 1'b1;
            flg_mask = flg_mask_of(op_q);
            flg_val  = flags_q;
            done     = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rmw_sequencer.sv
// Randomized scoreboard bench for rmw_sequencer with a behavioural ALU and reference model.
// Latency: checks done lands 3 cycles after start plus one per stalled READ cycle.
// Backpressure: drives rdy low in READ for a chosen number of cycles and randomly elsewhere.
module tb_rmw_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [15:0] addr;
   logic        c_in;
   logic        rdy;
   logic [7:0]  rdata;
   logic [15:0] bus_addr;
   logic        bus_re;
   logic        bus_we;
   logic [7:0]  wdata;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_c;
   logic [3:0]  alu_control;
   logic [7:0]  alu_y;
   logic [3:0]  alu_flgs;
   logic        flg_we;
   logic [3:0]  flg_mask;
   logic [3:0]  flg_val;
   logic        busy;
   logic        done;

   rmw_sequencer #(.ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .c_in(c_in),
      .rdy(rdy), .rdata(rdata), .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
      .wdata(wdata), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .alu_control(alu_control), .alu_y(alu_y), .alu_flgs(alu_flgs),
      .flg_we(flg_we), .flg_mask(flg_mask), .flg_val(flg_val), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the CPU's shared ALU; carry-in only matters to the rotates.
   logic       alu_v;
   logic       alu_cf;
   logic [8:0] sum;
   always_comb begin
      alu_y  = '0;
      alu_v  = 1'b0;
      alu_cf = 1'b0;
      sum    = '0;
      case (alu_control)
         4'b0000: begin
            sum    = {1'b0, alu_a} + {1'b0, alu_b};
            alu_y  = sum[7:0];
            alu_cf = sum[8];
            alu_v  = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
         end
         4'b0010: begin
            alu_y  = alu_a - alu_b;
            alu_cf = (alu_a >= alu_b);
            alu_v  = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
         end
         4'b1000: begin alu_y = {alu_a[6:0], 1'b0};  alu_cf = alu_a[7]; end
         4'b1001: begin alu_y = {alu_a[6:0], alu_c}; alu_cf = alu_a[7]; end
         4'b1010: begin alu_y = {1'b0, alu_a[7:1]};  alu_cf = alu_a[0]; end
         4'b1011: begin alu_y = {alu_c, alu_a[7:1]}; alu_cf = alu_a[0]; end
         default: begin end
      endcase
   end
   assign alu_flgs = {alu_y[7], alu_v, (alu_y == 8'd0), alu_cf};

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input bit ok, input string nm, input int act, input int exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      bit          fin;
      logic [7:0]  a;
      logic [7:0]  b;
      logic        c;
      logic [3:0]  ctl;
      logic [3:0]  fv;
      logic [3:0]  fm;
   } exp_t;
   exp_t exp_q[$];

   // Architectural behaviour of each RMW op, in plain integer arithmetic.
   function automatic void ref_model(input int o, input int x, input int ci,
                                     output logic [7:0] res, output logic [3:0] fl,
                                     output logic [3:0] ctl, output logic [7:0] b,
                                     output logic [3:0] msk);
      int r, cy, ov;
      r = 0; cy = 0; ov = 0; ctl = 4'b0000; b = 8'd0; msk = 4'b1011;
      case (o)
         0: begin r = (x * 2) % 256;          cy = x / 128;           ctl = 4'b1000; end
         1: begin r = x / 2;                  cy = x % 2;             ctl = 4'b1010; end
         2: begin r = (x * 2 + ci) % 256;     cy = x / 128;           ctl = 4'b1001; end
         3: begin r = x / 2 + ci * 128;       cy = x % 2;             ctl = 4'b1011; end
         4: begin r = (x + 1) % 256;          cy = (x == 255) ? 1 : 0; ov = (x == 127) ? 1 : 0;
                  ctl = 4'b0000; b = 8'd1; msk = 4'b1010; end
         default: begin r = (x + 255) % 256; cy = (x >= 1) ? 1 : 0;   ov = (x == 128) ? 1 : 0;
                  ctl = 4'b0010; b = 8'd1; msk = 4'b1010; end
      endcase
      res   = 8'(r);
      fl[3] = (r >= 128);
      fl[2] = (ov != 0);
      fl[1] = (r == 0);
      fl[0] = (cy != 0);
   endfunction

   // Monitor: every write strobe must match the next expected write in order.
   always @(negedge clk) begin
      if (rst_n && bus_we) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_write", int'(bus_addr), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(bus_addr === e.addr, "write_addr", int'(bus_addr), int'(e.addr));
            check(wdata === e.data, e.fin ? "final_wdata" : "dummy_wdata", int'(wdata), int'(e.data));
            check({flg_we, done} === {e.fin, e.fin}, "flg_we_done", int'({flg_we, done}), int'({e.fin, e.fin}));
            if (e.fin) begin
               check(flg_val === e.fv, "flg_val", int'(flg_val), int'(e.fv));
               check(flg_mask === e.fm, "flg_mask", int'(flg_mask), int'(e.fm));
            end else begin
               check({alu_control, alu_a, alu_b, alu_c} === {e.ctl, e.a, e.b, e.c}, "alu_drive",
                     int'({alu_control, alu_a, alu_b, alu_c}), int'({e.ctl, e.a, e.b, e.c}));
            end
         end
      end
      if (!busy) begin
         check({bus_addr, bus_re, bus_we, wdata, alu_a, alu_b, alu_c, alu_control,
                flg_we, flg_mask, flg_val, done} === '0, "idle_outputs_zero",
               int'({bus_re, bus_we, flg_we, done, alu_control}), 0);
      end
   end

   // One full operation: issue, push expected writes, stall READ, check timing.
   task automatic run_op(input int o, input logic [15:0] a, input logic ci,
                         input logic [7:0] v, input int stalls, input bit mid_start);
      exp_t e1, e2;
      logic [7:0] res, b;
      logic [3:0] fl, ctl, msk;
      bit got;
      ref_model(o, int'(v), int'(ci), res, fl, ctl, b, msk);
      e1 = '{addr: a, data: v,   fin: 1'b0, a: v, b: b, c: ci, ctl: ctl, fv: 4'h0, fm: 4'h0};
      e2 = '{addr: a, data: res, fin: 1'b1, a: v, b: b, c: ci, ctl: ctl, fv: fl,   fm: msk};
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      start = 1'b1; op = 3'(o); addr = a; c_in = ci;
      rdy = 1'($urandom); rdata = 8'($urandom);
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); addr = 16'($urandom); c_in = 1'($urandom);
      got = 1'b0;
      for (int cyc = 1; cyc <= stalls + 8 && !got; cyc++) begin
         if (cyc <= stalls) begin
            rdy = 1'b0; rdata = 8'($urandom);
         end else if (cyc == stalls + 1) begin
            rdy = 1'b1; rdata = v;
         end else begin
            rdy = 1'($urandom); rdata = 8'($urandom);
         end
         if (mid_start && cyc == stalls + 2) begin
            start = 1'b1; op = 3'($urandom_range(0, 5)); addr = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         check(busy === 1'b1, "busy_in_sequence", int'(busy), 1);
         if (cyc <= stalls + 1)
            check(bus_re === 1'b1 && bus_addr === a, "read_phase", int'(bus_addr), int'(a));
         if (done === 1'b1) begin
            check(cyc == stalls + 3, "done_cycle", cyc, stalls + 3);
            got = 1'b1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (!got) check(1'b0, "done_timeout", 0, 1);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; c_in = 1'b0; rdy = 1'b1; rdata = '0;
      #2;
      check({bus_re, bus_we, busy, done, flg_we} === 5'b0, "reset_state",
            int'({bus_re, bus_we, busy, done, flg_we}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases from the bring-up list.
      run_op(0, 16'h0080, 1'b0, 8'h81, 0, 1'b0);   // ASL 0x81 -> 0x02, C
      run_op(3, 16'h0200, 1'b1, 8'h01, 0, 1'b0);   // ROR 0x01 c=1 -> 0x80, N C
      run_op(5, 16'h0300, 1'b0, 8'h00, 0, 1'b0);   // DEC 0x00 -> 0xFF
      run_op(4, 16'h0301, 1'b1, 8'hFF, 0, 1'b0);   // INC 0xFF -> 0x00
      run_op(0, 16'h4000, 1'b0, 8'h40, 3, 1'b0);   // 3-cycle rdy stall, done in cycle 6
      run_op(2, 16'h1234, 1'b1, 8'h80, 1, 1'b1);   // start pulsed during DUMMY

      // Starts during a sequence must not spawn a second one.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check(busy === 1'b0, "no_extra_sequence", int'(busy), 0);
         @(posedge clk); #1;
      end

      // Reserved opcode must leave the bus quiet.
      start = 1'b1; op = 3'd6; addr = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check(busy === 1'b0 && bus_re === 1'b0, "reserved_op_ignored", int'({busy, bus_re}), 0);
         @(posedge clk); #1;
      end

      // Reset asserted while the dummy write is on the bus.
      start = 1'b1; op = 3'd0; addr = 16'h0777; c_in = 1'b0; rdy = 1'b1; rdata = 8'h55;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check(bus_we === 1'b1, "dummy_before_reset", int'(bus_we), 1);
      #1 rst_n = 1'b0;
      #1;
      check({bus_we, busy, bus_addr} === '0, "async_reset_drop", int'({bus_we, busy}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check({busy, bus_we, done} === 3'b0, "no_resume_after_reset", int'({busy, bus_we, done}), 0);
         @(posedge clk); #1;
      end

      // Randomized back-to-back traffic.
      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(0, 5)), 16'($urandom), 1'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      end

      cnt = 0;
      while (exp_q.size() != 0 && cnt < 20) begin
         @(posedge clk);
         cnt++;
      end
      check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
